// File: rtl/excp_int_ctrl_if.sv
// Commit-request and IF1-redirect handshake bundle for excp_int_ctrl.
// master = pipeline side, slave = exception/interrupt controller.
interface excp_int_ctrl_if #(
  parameter int ECODE_W = 15
);
  logic               req_valid;
  logic               req_ready;
  logic               req_excp;
  logic [ECODE_W-1:0] req_ecode;
  logic               req_ertn;
  logic [31:0]        req_epc;
  logic               req_badv_vld;
  logic [31:0]        req_badv;
  logic               redir_valid;
  logic [31:0]        redir_pc;
  logic               redir_ready;

  modport master (
    output req_valid,
    input  req_ready,
    output req_excp,
    output req_ecode,
    output req_ertn,
    output req_epc,
    output req_badv_vld,
    output req_badv,
    input  redir_valid,
    input  redir_pc,
    output redir_ready
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_excp,
    input  req_ecode,
    input  req_ertn,
    input  req_epc,
    input  req_badv_vld,
    input  req_badv,
    output redir_valid,
    output redir_pc,
    input  redir_ready
  );
endinterface

// File: rtl/excp_int_ctrl.sv
// Registered exception / interrupt / ertn commit controller.
// Builds the int vector, issues a one-cycle CSR write + flush, holds redirect.
module excp_int_ctrl #(
  parameter int                 HWI_NUM     = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [HWI_NUM-1:0] EDGE_MASK   = '0,
  parameter int                 ECODE_W     = 15,
  localparam int                IV_W        = HWI_NUM + 5
) (
  input  logic               clk,
  input  logic               rst_n,
  excp_int_ctrl_if.slave     bus,
  input  logic [HWI_NUM-1:0] hwi_in,
  input  logic               ti_in,
  input  logic               ipi_in,
  input  logic [IV_W-1:0]    int_clr,
  input  logic [1:0]         csr_crmd_plv,
  input  logic               csr_crmd_ie,
  input  logic [1:0]         csr_prmd_pplv,
  input  logic               csr_prmd_pie,
  input  logic [1:0]         csr_swi,
  input  logic [IV_W-1:0]    csr_lie,
  input  logic [31:0]        csr_era,
  input  logic [31:0]        csr_eentry,
  input  logic [31:0]        csr_tlbrentry,
  output logic               excp_flush,
  output logic               csr_we,
  output logic [1:0]         wr_crmd_plv,
  output logic               wr_crmd_ie,
  output logic [1:0]         wr_prmd_pplv,
  output logic               wr_prmd_pie,
  output logic [31:0]        wr_era,
  output logic [IV_W-1:0]    wr_estat_is,
  output logic               wr_ecode_we,
  output logic [ECODE_W-1:0] wr_ecode,
  output logic               wr_badv_we,
  output logic [31:0]        wr_badv,
  output logic [IV_W-1:0]    int_pending
);

  typedef enum logic {
    S_IDLE,
    S_REDIR
  } state_e;

  localparam int SW = SYNC_STAGES * HWI_NUM;

  logic [SW-1:0]      sync_q, sync_d;
  logic [HWI_NUM-1:0] prev_q, prev_d;
  logic [HWI_NUM-1:0] pend_q, pend_d;
  logic [HWI_NUM-1:0] hwi_s, hwi_v;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               evt_q, evt_d;
  logic               ecode_we_q, ecode_we_d;
  logic               badv_we_q, badv_we_d;
  logic [1:0]         plv_q, plv_d;
  logic               ie_q, ie_d;
  logic [1:0]         pplv_q, pplv_d;
  logic               pie_q, pie_d;
  logic [31:0]        era_q, era_d;
  logic [IV_W-1:0]    estat_q, estat_d;
  logic [ECODE_W-1:0] ecode_q, ecode_d;
  logic [31:0]        badv_q, badv_d;
  logic [31:0]        pc_q, pc_d;

  logic is_int;
  logic has_evt;
  logic accept;
  logic unused_clr;

  assign hwi_s = sync_q[SW-1 -: HWI_NUM];
  assign hwi_v = (EDGE_MASK & pend_q) | (~EDGE_MASK & hwi_s);

  assign int_pending = {ipi_in, ti_in, 1'b0, hwi_v, csr_swi};

  // Only the hwi slots of int_clr map onto sticky pending bits.
  assign unused_clr = ^{int_clr[IV_W-1:HWI_NUM+2], int_clr[1:0]};

  assign is_int  = csr_crmd_ie & |(int_pending & csr_lie);
  assign has_evt = is_int | bus.req_excp | bus.req_ertn;
  assign accept  = bus.req_valid & ready_q & has_evt;

  assign bus.req_ready   = ready_q;
  assign bus.redir_valid = (state_q == S_REDIR);
  assign bus.redir_pc    = pc_q;

  assign csr_we       = evt_q;
  assign excp_flush   = evt_q;
  assign wr_ecode_we  = ecode_we_q;
  assign wr_badv_we   = badv_we_q;
  assign wr_crmd_plv  = plv_q;
  assign wr_crmd_ie   = ie_q;
  assign wr_prmd_pplv = pplv_q;
  assign wr_prmd_pie  = pie_q;
  assign wr_era       = era_q;
  assign wr_estat_is  = estat_q;
  assign wr_ecode     = ecode_q;
  assign wr_badv      = badv_q;

  // Synchroniser shift, edge history and sticky edge pending (set beats clear).
  always_comb begin
    sync_d = {sync_q[SW-HWI_NUM-1:0], hwi_in};
    prev_d = hwi_s;
    pend_d = (pend_q & ~int_clr[HWI_NUM+1:2]) | (hwi_s & ~prev_q);
    pend_d = pend_d & EDGE_MASK;
  end

  // Handshake FSM and registered CSR update values captured at acceptance.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    evt_d      = 1'b0;
    ecode_we_d = 1'b0;
    badv_we_d  = 1'b0;
    plv_d      = plv_q;
    ie_d       = ie_q;
    pplv_d     = pplv_q;
    pie_d      = pie_q;
    era_d      = era_q;
    estat_d    = estat_q;
    ecode_d    = ecode_q;
    badv_d     = badv_q;
    pc_d       = pc_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d = S_REDIR;
          ready_d = 1'b0;
          evt_d   = 1'b1;
          estat_d = int_pending;
          if (is_int) begin
            plv_d      = 2'd0;
            ie_d       = 1'b0;
            pplv_d     = csr_crmd_plv;
            pie_d      = csr_crmd_ie;
            era_d      = bus.req_epc;
            ecode_d    = '0;
            ecode_we_d = 1'b1;
            pc_d       = csr_eentry;
          end else if (bus.req_excp) begin
            plv_d      = 2'd0;
            ie_d       = 1'b0;
            pplv_d     = csr_crmd_plv;
            pie_d      = csr_crmd_ie;
            era_d      = bus.req_epc;
            ecode_d    = bus.req_ecode;
            ecode_we_d = 1'b1;
            badv_we_d  = bus.req_badv_vld;
            badv_d     = bus.req_badv;
            pc_d       = (bus.req_ecode[5:0] == 6'h3F)
                       ? csr_tlbrentry : csr_eentry;
          end else begin
            plv_d  = csr_prmd_pplv;
            ie_d   = csr_prmd_pie;
            pplv_d = csr_prmd_pplv;
            pie_d  = csr_prmd_pie;
            era_d  = csr_era;
            pc_d   = csr_era;
          end
        end
      end
      S_REDIR: begin
        ready_d = 1'b0;
        if (bus.redir_ready) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      evt_q      <= 1'b0;
      ecode_we_q <= 1'b0;
      badv_we_q  <= 1'b0;
      plv_q      <= '0;
      ie_q       <= 1'b0;
      pplv_q     <= '0;
      pie_q      <= 1'b0;
      era_q      <= '0;
      estat_q    <= '0;
      ecode_q    <= '0;
      badv_q     <= '0;
      pc_q       <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      ready_q    <= ready_d;
      evt_q      <= evt_d;
      ecode_we_q <= ecode_we_d;
      badv_we_q  <= badv_we_d;
      plv_q      <= plv_d;
      ie_q       <= ie_d;
      pplv_q     <= pplv_d;
      pie_q      <= pie_d;
      era_q      <= era_d;
      estat_q    <= estat_d;
      ecode_q    <= ecode_d;
      badv_q     <= badv_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_excp_int_ctrl.sv
// Directed bench for excp_int_ctrl: vector table plus multi-cycle sequences.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_excp_int_ctrl;
  localparam int HWI  = 8;
  localparam int IVW  = HWI + 5;
  localparam int EW   = 15;
  localparam logic [31:0] EENTRY = 32'h1C00C000;
  localparam logic [31:0] TLBR   = 32'h1C008000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [HWI-1:0] hwi_in;
  logic           ti_in, ipi_in;
  logic [IVW-1:0] int_clr;
  logic [1:0]     csr_crmd_plv, csr_prmd_pplv, csr_swi;
  logic           csr_crmd_ie, csr_prmd_pie;
  logic [IVW-1:0] csr_lie;
  logic [31:0]    csr_era, csr_eentry, csr_tlbrentry;
  logic           excp_flush, csr_we;
  logic [1:0]     wr_crmd_plv, wr_prmd_pplv;
  logic           wr_crmd_ie, wr_prmd_pie;
  logic [31:0]    wr_era, wr_badv;
  logic [IVW-1:0] wr_estat_is, int_pending;
  logic           wr_ecode_we, wr_badv_we;
  logic [EW-1:0]  wr_ecode;

  int checks = 0;
  int errors = 0;

  excp_int_ctrl_if #(.ECODE_W(EW)) bus ();

  excp_int_ctrl #(
    .HWI_NUM(HWI), .SYNC_STAGES(2),
    .EDGE_MASK(8'h08), .ECODE_W(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hwi_in(hwi_in), .ti_in(ti_in), .ipi_in(ipi_in),
    .int_clr(int_clr),
    .csr_crmd_plv(csr_crmd_plv), .csr_crmd_ie(csr_crmd_ie),
    .csr_prmd_pplv(csr_prmd_pplv), .csr_prmd_pie(csr_prmd_pie),
    .csr_swi(csr_swi), .csr_lie(csr_lie),
    .csr_era(csr_era), .csr_eentry(csr_eentry),
    .csr_tlbrentry(csr_tlbrentry),
    .excp_flush(excp_flush), .csr_we(csr_we),
    .wr_crmd_plv(wr_crmd_plv), .wr_crmd_ie(wr_crmd_ie),
    .wr_prmd_pplv(wr_prmd_pplv), .wr_prmd_pie(wr_prmd_pie),
    .wr_era(wr_era), .wr_estat_is(wr_estat_is),
    .wr_ecode_we(wr_ecode_we), .wr_ecode(wr_ecode),
    .wr_badv_we(wr_badv_we), .wr_badv(wr_badv),
    .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          excp;
    logic          ertn;
    logic [EW-1:0] ecode;
    logic [31:0]   epc;
    logic          bvld;
    logic [31:0]   badv;
    logic [1:0]    plv;
    logic          ie;
    logic [1:0]    pplv;
    logic          pie;
    logic [31:0]   era;
    logic          evt;
    logic [1:0]    e_plv;
    logic          e_ie;
    logic [1:0]    e_pplv;
    logic          e_pie;
    logic [31:0]   e_era;
    logic [31:0]   e_pc;
    logic [EW-1:0] e_ecode;
    logic          e_ecode_we;
    logic          e_badv_we;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_req();
    bus.req_valid    = 1'b0;
    bus.req_excp     = 1'b0;
    bus.req_ertn     = 1'b0;
    bus.req_ecode    = '0;
    bus.req_epc      = '0;
    bus.req_badv_vld = 1'b0;
    bus.req_badv     = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 15'h003F, 32'h1C000100, 1'b1, 32'hDEAD0000,
                2'd3, 1'b1, 2'd0, 1'b0, 32'h1C000A00,
                1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 32'h1C000100, TLBR,
                15'h003F, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 15'h0048, 32'h1C000104, 1'b0, 32'h00000000,
                2'd0, 1'b0, 2'd2, 1'b1, 32'h1C000A00,
                1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 32'h1C000104, EENTRY,
                15'h0048, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 15'h007F, 32'h1C000108, 1'b1, 32'h00001234,
                2'd1, 1'b1, 2'd0, 1'b0, 32'h1C000A00,
                1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 32'h1C000108, TLBR,
                15'h007F, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 15'h0000, 32'h1C000300, 1'b0, 32'h00000000,
                2'd0, 1'b0, 2'd3, 1'b1, 32'h1C000200,
                1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 32'h1C000200, 32'h1C000200,
                15'h0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 15'h0001, 32'h1C00010C, 1'b0, 32'h00000000,
                2'd2, 1'b0, 2'd1, 1'b1, 32'h1C000200,
                1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 32'h1C00010C, EENTRY,
                15'h0001, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 15'h0000, 32'h1C000400, 1'b0, 32'h00000000,
                2'd0, 1'b0, 2'd0, 1'b0, 32'h1C000200,
                1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0,
                15'h0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    hwi_in = '0; ti_in = 1'b0; ipi_in = 1'b0; int_clr = '0;
    csr_crmd_plv = '0; csr_crmd_ie = 1'b0;
    csr_prmd_pplv = '0; csr_prmd_pie = 1'b0;
    csr_swi = '0; csr_lie = '0;
    csr_era = '0; csr_eentry = EENTRY; csr_tlbrentry = TLBR;
    bus.redir_ready = 1'b1;
    idle_req();

    // reset
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rvalid", bus.redir_valid, 0);
    chk("rst_rpc", bus.redir_pc, 0);
    chk("rst_we", csr_we, 0);
    chk("rst_flush", excp_flush, 0);
    chk("rst_era", wr_era, 0);
    chk("rst_pend", int_pending, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.req_ready, 1);

    // table-driven requests
    for (int i = 0; i < 6; i++) begin
      csr_crmd_plv  = vecs[i].plv;
      csr_crmd_ie   = vecs[i].ie;
      csr_prmd_pplv = vecs[i].pplv;
      csr_prmd_pie  = vecs[i].pie;
      csr_era       = vecs[i].era;
      bus.redir_ready  = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_excp     = vecs[i].excp;
      bus.req_ertn     = vecs[i].ertn;
      bus.req_ecode    = vecs[i].ecode;
      bus.req_epc      = vecs[i].epc;
      bus.req_badv_vld = vecs[i].bvld;
      bus.req_badv     = vecs[i].badv;
      @(negedge clk);
      idle_req();
      csr_crmd_plv = 2'd2; csr_crmd_ie = 1'b1;
      csr_prmd_pplv = 2'd1; csr_prmd_pie = 1'b0;
      csr_era = 32'hFFFF0000;
      chk($sformatf("v%0d_we", i), csr_we, vecs[i].evt);
      chk($sformatf("v%0d_flush", i), excp_flush, vecs[i].evt);
      chk($sformatf("v%0d_rvalid", i), bus.redir_valid, vecs[i].evt);
      chk($sformatf("v%0d_ready", i), bus.req_ready, !vecs[i].evt);
      if (vecs[i].evt) begin
        chk($sformatf("v%0d_pc", i), bus.redir_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_plv", i), wr_crmd_plv, vecs[i].e_plv);
        chk($sformatf("v%0d_ie", i), wr_crmd_ie, vecs[i].e_ie);
        chk($sformatf("v%0d_pplv", i), wr_prmd_pplv, vecs[i].e_pplv);
        chk($sformatf("v%0d_pie", i), wr_prmd_pie, vecs[i].e_pie);
        chk($sformatf("v%0d_era", i), wr_era, vecs[i].e_era);
        chk($sformatf("v%0d_ecwe", i), wr_ecode_we, vecs[i].e_ecode_we);
        chk($sformatf("v%0d_bvwe", i), wr_badv_we, vecs[i].e_badv_we);
        if (vecs[i].e_ecode_we)
          chk($sformatf("v%0d_ecode", i), wr_ecode, vecs[i].e_ecode);
        if (vecs[i].e_badv_we)
          chk($sformatf("v%0d_badv", i), wr_badv, vecs[i].badv);
        @(negedge clk);
        chk($sformatf("v%0d_we1", i), csr_we, 0);
        chk($sformatf("v%0d_rv1", i), bus.redir_valid, 0);
        chk($sformatf("v%0d_rdy1", i), bus.req_ready, 1);
        chk($sformatf("v%0d_era_hold", i), wr_era, vecs[i].e_era);
        chk($sformatf("v%0d_plv_hold", i), wr_crmd_plv, vecs[i].e_plv);
      end
    end

    // timer and ipi slots of the int vector
    ti_in = 1'b1;
    #1 chk("ti_slot", int_pending, 13'h0800);
    ti_in = 1'b0; ipi_in = 1'b1;
    #1 chk("ipi_slot", int_pending, 13'h1000);
    ipi_in = 1'b0;

    // interrupt beats exception, level hwi through 2 sync stages
    @(negedge clk);
    csr_lie = 13'h004; csr_crmd_ie = 1'b1; csr_crmd_plv = 2'd3;
    hwi_in[0] = 1'b1;
    @(negedge clk);
    chk("lvl_sync1", int_pending, 0);
    @(negedge clk);
    chk("lvl_sync2", int_pending, 13'h004);
    bus.req_valid = 1'b1; bus.req_excp = 1'b1;
    bus.req_ecode = 15'h003F; bus.req_epc = 32'h1C000500;
    bus.req_badv_vld = 1'b1;
    @(negedge clk);
    idle_req();
    hwi_in[0] = 1'b0; csr_lie = '0; csr_crmd_ie = 1'b0;
    chk("int_we", csr_we, 1);
    chk("int_ecode", wr_ecode, 0);
    chk("int_ecwe", wr_ecode_we, 1);
    chk("int_estat", wr_estat_is, 13'h004);
    chk("int_pc", bus.redir_pc, EENTRY);
    chk("int_era", wr_era, 32'h1C000500);
    chk("int_pplv", wr_prmd_pplv, 2'd3);
    chk("int_pie", wr_prmd_pie, 1);
    chk("int_bvwe", wr_badv_we, 0);
    @(negedge clk);
    chk("int_ready", bus.req_ready, 1);
    repeat (3) @(negedge clk);

    // edge-latched hwi[3] -> int_pending[5]
    hwi_in[3] = 1'b1;
    @(negedge clk);
    hwi_in[3] = 1'b0;
    chk("edge_t0", int_pending[5], 0);
    @(negedge clk);
    chk("edge_t1", int_pending[5], 0);
    @(negedge clk);
    chk("edge_t2", int_pending[5], 1);
    repeat (3) @(negedge clk);
    chk("edge_sticky", int_pending[5], 1);
    int_clr[5] = 1'b1;
    @(negedge clk);
    int_clr = '0;
    chk("edge_clr", int_pending[5], 0);
    hwi_in[3] = 1'b1;
    @(negedge clk);
    hwi_in[3] = 1'b0;
    @(negedge clk);
    int_clr[5] = 1'b1;
    @(negedge clk);
    int_clr = '0;
    chk("edge_set_wins", int_pending[5], 1);
    @(negedge clk);
    chk("edge_set_hold", int_pending[5], 1);
    int_clr[5] = 1'b1;
    @(negedge clk);
    int_clr = '0;

    // ertn with redirect back-pressure
    csr_prmd_pplv = 2'd3; csr_prmd_pie = 1'b1;
    csr_era = 32'h1C000200; csr_crmd_plv = 2'd0;
    bus.redir_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_ertn = 1'b1;
    bus.req_epc = 32'h1C000600;
    @(negedge clk);
    bus.req_ertn = 1'b0; bus.req_excp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_rvalid", i), bus.redir_valid, 1);
      chk($sformatf("bp%0d_pc", i), bus.redir_pc, 32'h1C000200);
      chk($sformatf("bp%0d_ready", i), bus.req_ready, 0);
      chk($sformatf("bp%0d_we", i), csr_we, i == 0);
      if (i == 4) begin
        bus.redir_ready = 1'b1;
        idle_req();
      end
      @(negedge clk);
    end
    chk("bp_plv", wr_crmd_plv, 2'd3);
    chk("bp_ie", wr_crmd_ie, 1);
    chk("bp_done_rv", bus.redir_valid, 0);
    chk("bp_done_rdy", bus.req_ready, 1);

    // reset while in redirect
    bus.redir_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_excp = 1'b1;
    bus.req_ecode = 15'h0008; bus.req_epc = 32'h1C000700;
    @(negedge clk);
    idle_req();
    chk("mid_rvalid", bus.redir_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rv", bus.redir_valid, 0);
    chk("mid_rst_we", csr_we, 0);
    chk("mid_rst_era", wr_era, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_rdy", bus.req_ready, 1);
    chk("mid_rel_we", csr_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/excp_int_ctrl.md
# excp_int_ctrl

Parametrised, registered successor to the combinational exception/ertn commit logic. Takes the commit-stage request, arbitrates interrupt > exception > ertn, and issues a one-cycle CSR update and pipeline flush. It then holds a redirect request to IF1 until accepted. Adds configurable hardware-interrupt count, input synchronisers, and per-line edge/level capture with software clear.

## Interface
Parameters:
- HWI_NUM, 8: hardware interrupt lines; int vector width IV_W = HWI_NUM+5, layout {ipi, ti, 1'b0, hwi[HWI_NUM-1:0], swi[1:0]}
- SYNC_STAGES, 2: flop stages on hwi_in (≥2)
- EDGE_MASK, 0 (HWI_NUM bits): bit=1 → that hwi line is rising-edge latched, else level
- ECODE_W, 15: {esubcode, ecode} width; ecode = low 6 bits

Ports (reset is synchronous, active-low, on `clk`):
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- hwi_in  in  HWI_NUM  asynchronous hardware interrupts
- ti_in  in  1  timer interrupt (clk domain, level)
- ipi_in  in  1  inter-processor interrupt (clk domain, level)
- int_clr  in  IV_W  one-cycle clear pulses for edge-latched pending bits
- req_valid  in  1  commit-stage instruction valid
- req_ready  out  1  unit can accept a request
- req_excp  in  1  instruction carries exception
- req_ecode  in  ECODE_W  {esubcode, ecode}
- req_ertn  in  1  instruction is ertn
- req_epc  in  32  instruction PC
- req_badv_vld  in  1  req_badv meaningful
- req_badv  in  32  faulting address
- csr_crmd_plv / csr_crmd_ie / csr_prmd_pplv / csr_prmd_pie  in  2/1/2/1  current CSR fields
- csr_swi  in  2  ESTAT.IS[1:0]
- csr_lie  in  IV_W  ECFG.LIE
- csr_era / csr_eentry / csr_tlbrentry  in  32 each
- excp_flush  out  1  flush pulse to pipeline control
- redir_valid  out  1  PC redirect to IF1
- redir_pc  out  32  redirect target
- redir_ready  in  1  IF1 accepts redirect
- csr_we  out  1  CSR update strobe
- wr_crmd_plv / wr_crmd_ie / wr_prmd_pplv / wr_prmd_pie  out  2/1/2/1
- wr_era  out  32
- wr_estat_is  out  IV_W
- wr_ecode_we  out  1;  wr_ecode  out  ECODE_W
- wr_badv_we  out  1;  wr_badv  out  32
- int_pending  out  IV_W  current int vector (debug and CSR read)

## Operation
- Int vector: hwi lines pass through SYNC_STAGES flops. Level lines use the synced value. Edge lines set a sticky pending bit when the synced value rises (synced & ~prev_synced). int_clr clears the bit; set wins over clear in the same cycle. ti, ipi, swi are used directly.
- is_int = csr_crmd_ie & |(int_pending & csr_lie).
- Event accepted in cycle t when req_valid & req_ready & (is_int | req_excp | req_ertn). Priority: int > excp > ertn. A request with no event is consumed with no action.
- int: plv←0, ie←0, pplv←crmd_plv, pie←crmd_ie, era←req_epc, estat_is←int_pending, wr_ecode←0 (INT), wr_ecode_we=1, target=csr_eentry.
- excp: same as int except estat_is is not written (hold csr_swi-inclusive input value) and wr_ecode←req_ecode. Target is csr_tlbrentry if ecode[5:0]==6'h3F, else csr_eentry. wr_badv_we←req_badv_vld, wr_badv←req_badv.
- ertn: plv←prmd_pplv, ie←prmd_pie, other fields hold their CSR inputs, wr_ecode_we=0, target=csr_era.
- FSM: IDLE (req_ready=1) → REDIRECT on an accepted event. REDIRECT (req_ready=0, redir_valid=1) → IDLE when redir_ready=1.

## Timing
- Reset values: all outputs 0, except req_ready=1 once the next cycle is in IDLE. Sync and pending flops 0. State IDLE.
- Event at edge t → at t+1, csr_we, excp_flush, wr_*_we are 1 for exactly one cycle. redir_valid=1 with redir_pc stable from t+1 until the handshake cycle inclusive.
- All wr_* values are registered from cycle-t inputs. CSR inputs changing later have no effect.
- redir_ready sampled at t+1: if 1, back in IDLE at t+2 and req_ready=1 at t+2. Otherwise hold.
- Level hwi rising before edge k appears in int_pending after edge k+SYNC_STAGES-1. Edge line pending appears one cycle later (k+SYNC_STAGES).
- Reset asserted in REDIRECT: redir_valid=0 and state IDLE next cycle, with no CSR write.
- Requests presented while req_ready=0 are ignored; upstream holds them.

## Test plan
- Reset: rst_n=0 for 2 cycles → all outputs 0, req_ready=1 after release.
- Excp TLBR: req_excp=1, ecode=15'h003F, epc=0x1C000100, tlbrentry=0x1C008000, redir_ready=1 → one-cycle csr_we/flush, wr_era=0x1C000100, redir_pc=0x1C008000, req_ready back after 2 cycles.
- Int beats excp: lie bit 2 set, hwi_in[0]=1 (level), crmd_ie=1, and req_excp=1 after 2 sync cycles → wr_ecode=0, wr_estat_is=13'h004, redir_pc=eentry.
- Edge latch: EDGE_MASK[3]=1, 1-cycle hwi_in[3] pulse → int_pending[5]=1 at t+SYNC_STAGES and stays set. int_clr[5] pulse clears it. Same-cycle new edge plus clear → stays 1.
- Ertn with back-pressure: prmd_pplv=3, pie=1, era=0x1C000200, redir_ready low 4 cycles → redir_valid held 5 cycles, pc constant, req_ready=0 throughout, wr_crmd_plv=3.
- Reset mid-REDIRECT → redir_valid=0 next cycle, no further csr_we.
